// File: rtl/uart_rx_fifo_if.sv
// Read-side handshake and status bundle of the UART receive FIFO.
// The receiver drives it through the master modport.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                        rd_ready;
    logic                        rd_valid;
    logic [DATA_BITS-1:0]        rd_data;
    logic                        rd_parity_err;
    logic                        rd_frame_err;
    logic                        overrun;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        busy;

    modport master (
        input  rd_ready,
        output rd_valid, rd_data, rd_parity_err, rd_frame_err, overrun, fifo_count, busy
    );

    modport slave (
        output rd_ready,
        input  rd_valid, rd_data, rd_parity_err, rd_frame_err, overrun, fifo_count, busy
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with configurable frame format, feeding a
// show-ahead FIFO that stores each word together with its parity/stop error flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    uart_rx_fifo_if.master rd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = DATA_BITS + 2;
    localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_MODE == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [3:0]           bit_cnt, bit_cnt_nxt;
    logic                 armed, armed_nxt;
    logic                 par_err, par_err_nxt;
    logic                 frm_err, frm_err_nxt;
    logic                 push, shift_en, tick;
    logic                 rx_p0, rx_p1, rxs;
    logic [DATA_BITS-1:0] shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end
    assign rxs = rx_p1;

    // ---- receive FSM: state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            armed   <= 1'b1;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            armed   <= armed_nxt;
            par_err <= par_err_nxt;
            frm_err <= frm_err_nxt;
        end
    end

    assign tick = (state == START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

    // armed drops after a low stop sample so a stuck-low line cannot retrigger
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        bit_cnt_nxt = bit_cnt;
        armed_nxt   = armed;
        par_err_nxt = par_err;
        frm_err_nxt = frm_err;
        push        = 1'b0;
        shift_en    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt     = '0;
                bit_cnt_nxt = '0;
                if (rxs) armed_nxt = 1'b1;
                if (!rxs && armed) begin
                    state_nxt   = START;
                    par_err_nxt = 1'b0;
                    frm_err_nxt = 1'b0;
                end
            end
            START: if (tick) begin
                cnt_nxt   = '0;
                state_nxt = rxs ? IDLE : DATA;
            end
            DATA: if (tick) begin
                cnt_nxt  = '0;
                shift_en = 1'b1;
                if (bit_cnt == LAST_DATA) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = (PARITY_MODE != 0) ? PARITY : STOP;
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            PARITY: if (tick) begin
                cnt_nxt     = '0;
                par_err_nxt = (rxs != (^shreg ^ ODD));
                state_nxt   = STOP;
            end
            STOP: if (tick) begin
                cnt_nxt = '0;
                if (!rxs) frm_err_nxt = 1'b1;
                if (bit_cnt == LAST_STOP) begin
                    push      = 1'b1;
                    armed_nxt = rxs;
                    state_nxt = IDLE;
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (shift_en) shreg <= {rxs, shreg[DATA_BITS-1:1]};
    end

    // ---- FIFO ----
    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [WW-1:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, wr_en, ovr;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign pop   = (count != '0) && rd.rd_ready;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
            if (pop)               ovr <= 1'b0;
            else if (push && full) ovr <= 1'b1;
        end
    end

    // the final stop sample is folded in combinationally so the word is stored on that edge
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {shreg, par_err, frm_err | ~rxs};
    end

    assign head             = mem[rd_ptr];
    assign rd.rd_valid      = (count != '0);
    assign rd.rd_data       = rd.rd_valid ? head[WW-1:2] : '0;
    assign rd.rd_parity_err = rd.rd_valid & head[1];
    assign rd.rd_frame_err  = rd.rd_valid & head[0];
    assign rd.overrun       = ovr;
    assign rd.fifo_count    = count;
    assign rd.busy          = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8E1/32-clk instance and a 7O2/16-clk instance.
module tb_uart_rx_fifo;
    localparam int CPB_A = 32;
    localparam int CPB_B = 16;

    logic clk, rst, rx_a, rx_b;
    int   passed = 0;
    int   fails  = 0;
    int   total  = 0;

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
    uart_rx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) ifb ();

    uart_rx_fifo #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut_a (.clk(clk), .rst(rst), .rx(rx_a), .rd(ifa.master));
    uart_rx_fifo #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4))
        dut_b (.clk(clk), .rst(rst), .rx(rx_b), .rd(ifb.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic par_even(input logic [7:0] d);
        return ^d;
    endfunction

    function automatic logic par_odd(input logic [6:0] d);
        return ~^d;
    endfunction

    task automatic drive_bit(input int which, input logic b, input int cpb);
        if (which == 0) rx_a = b;
        else            rx_b = b;
        repeat (cpb) @(negedge clk);
    endtask

    // pulse >= 0 raises A's rd_ready for one cycle at that offset into the last stop bit
    task automatic send(input int which, input logic [8:0] d, input int nd, input int cpb,
                        input logic par_en, input logic par, input logic stop1, input logic stop2,
                        input int nstop, input int pulse);
        drive_bit(which, 1'b0, cpb);
        for (int i = 0; i < nd; i++) drive_bit(which, d[i], cpb);
        if (par_en) drive_bit(which, par, cpb);
        if (nstop == 2) drive_bit(which, stop1, cpb);
        if (which == 0) rx_a = (nstop == 2) ? stop2 : stop1;
        else            rx_b = (nstop == 2) ? stop2 : stop1;
        for (int c = 0; c < cpb; c++) begin
            if (pulse >= 0 && c == pulse)          ifa.rd_ready = 1'b1;
            else if (pulse >= 0 && c == pulse + 1) ifa.rd_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic par, input logic stop, input int pulse);
        send(0, {1'b0, d}, 8, CPB_A, 1'b1, par, stop, 1'b1, 1, pulse);
    endtask

    task automatic send_b(input logic [6:0] d, input logic par, input logic stop2);
        send(1, {2'b00, d}, 7, CPB_B, 1'b1, par, 1'b1, stop2, 2, -1);
    endtask

    task automatic expect_head(input int which, input string tag, input logic [8:0] d,
                               input logic pe, input logic fe);
        logic       v;
        logic [8:0] data;
        int         n = 0;
        v = (which == 0) ? ifa.rd_valid : ifb.rd_valid;
        while (!v && n < 400) begin
            @(negedge clk);
            n++;
            v = (which == 0) ? ifa.rd_valid : ifb.rd_valid;
        end
        data = (which == 0) ? {1'b0, ifa.rd_data} : {2'b00, ifb.rd_data};
        check({tag, "_valid"}, 32'(v), 32'(1'b1));
        check({tag, "_data"}, 32'(data), 32'(d));
        check({tag, "_perr"}, 32'((which == 0) ? ifa.rd_parity_err : ifb.rd_parity_err), 32'(pe));
        check({tag, "_ferr"}, 32'((which == 0) ? ifa.rd_frame_err : ifb.rd_frame_err), 32'(fe));
        if (which == 0) ifa.rd_ready = 1'b1;
        else            ifb.rd_ready = 1'b1;
        @(negedge clk);
        ifa.rd_ready = 1'b0;
        ifb.rd_ready = 1'b0;
    endtask

    task automatic fill_a4();
        send_a(8'h61, par_even(8'h61), 1'b1, -1);
        send_a(8'h7E, par_even(8'h7E), 1'b1, -1);
        send_a(8'h87, par_even(8'h87), 1'b1, -1);
        send_a(8'h21, par_even(8'h21), 1'b1, -1);
    endtask

    task automatic drain_a(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3, input logic ovr0);
        ifa.rd_ready = 1'b1;
        check({tag, "_h0"}, 32'(ifa.rd_data), 32'(w0));
        check({tag, "_ovr0"}, 32'(ifa.overrun), 32'(ovr0));
        @(negedge clk);
        check({tag, "_h1"}, 32'(ifa.rd_data), 32'(w1));
        check({tag, "_ovr1"}, 32'(ifa.overrun), 32'(1'b0));
        check({tag, "_cnt1"}, 32'(ifa.fifo_count), 32'(3));
        @(negedge clk);
        check({tag, "_h2"}, 32'(ifa.rd_data), 32'(w2));
        @(negedge clk);
        check({tag, "_h3"}, 32'(ifa.rd_data), 32'(w3));
        @(negedge clk);
        check({tag, "_empty"}, 32'(ifa.rd_valid), 32'(1'b0));
        check({tag, "_cnt0"}, 32'(ifa.fifo_count), 32'(0));
        ifa.rd_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] va;
        logic [6:0] vb;
        rst = 1'b0;
        rx_a = 1'b1;
        rx_b = 1'b1;
        ifa.rd_ready = 1'b0;
        ifb.rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid_a", 32'(ifa.rd_valid), 32'(1'b0));
        check("rst_count_a", 32'(ifa.fifo_count), 32'(0));
        check("rst_busy_a", 32'(ifa.busy), 32'(1'b0));
        check("rst_ovr_a", 32'(ifa.overrun), 32'(1'b0));
        check("rst_data_a", 32'(ifa.rd_data), 32'(0));
        check("rst_busy_b", 32'(ifb.busy), 32'(1'b0));
        rst = 1'b1;
        repeat (3) @(negedge clk);

        send_a(8'hD1, par_even(8'hD1), 1'b1, -1);
        expect_head(0, "d1", 9'h0D1, 1'b0, 1'b0);
        check("d1_ovr", 32'(ifa.overrun), 32'(1'b0));

        send_a(8'h35, ~par_even(8'h35), 1'b1, -1);
        expect_head(0, "35", 9'h035, 1'b1, 1'b0);
        send_a(8'h4A, par_even(8'h4A), 1'b0, -1);
        check("low_stop_idle", 32'(ifa.busy), 32'(1'b0));
        expect_head(0, "4a", 9'h04A, 1'b0, 1'b1);
        rx_a = 1'b1;
        repeat (64) @(negedge clk);
        send_a(8'h5D, par_even(8'h5D), 1'b1, -1);
        expect_head(0, "5d", 9'h05D, 1'b0, 1'b0);

        // 8-clock glitch on idle line
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy", 32'(ifa.busy), 32'(1'b1));
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (CPB_A / 2 + 3 - 8) @(negedge clk);
        check("glitch_idle", 32'(ifa.busy), 32'(1'b0));
        check("glitch_count", 32'(ifa.fifo_count), 32'(0));

        fill_a4();
        check("full_count", 32'(ifa.fifo_count), 32'(4));
        check("full_ovr", 32'(ifa.overrun), 32'(1'b0));
        send_a(8'h66, par_even(8'h66), 1'b1, -1);
        check("ovr_set", 32'(ifa.overrun), 32'(1'b1));
        check("ovr_count", 32'(ifa.fifo_count), 32'(4));
        drain_a("ovr", 8'h61, 8'h7E, 8'h87, 8'h21, 1'b1);

        // pop exactly in the push cycle of a fifth frame
        fill_a4();
        send_a(8'h00, par_even(8'h00), 1'b1, CPB_A / 2 + 2);
        check("pp_count", 32'(ifa.fifo_count), 32'(4));
        check("pp_ovr", 32'(ifa.overrun), 32'(1'b0));
        drain_a("pp", 8'h7E, 8'h87, 8'h21, 8'h00, 1'b0);

        // break: one frame only, no free-running on a stuck-low line
        drive_bit(0, 1'b0, 1024);
        check("brk_count", 32'(ifa.fifo_count), 32'(1));
        check("brk_busy", 32'(ifa.busy), 32'(1'b0));
        expect_head(0, "brk", 9'h000, 1'b0, 1'b1);
        rx_a = 1'b1;
        repeat (40) @(negedge clk);

        // reset mid-frame, with a stale word already queued
        send_a(8'h5D, par_even(8'h5D), 1'b1, -1);
        va = 8'hE1;
        drive_bit(0, 1'b0, CPB_A);
        for (int i = 0; i < 4; i++) drive_bit(0, va[i], CPB_A);
        rx_a = va[4];
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_busy_a", 32'(ifa.busy), 32'(1'b0));
        check("mrst_count_a", 32'(ifa.fifo_count), 32'(0));
        rx_a = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_valid_a", 32'(ifa.rd_valid), 32'(1'b0));
        send_a(8'hE1, par_even(8'hE1), 1'b1, -1);
        expect_head(0, "e1", 9'h0E1, 1'b0, 1'b0);

        // 7 data bits, odd parity, 2 stop bits, 16 clks/bit
        send_b(7'h2A, par_odd(7'h2A), 1'b1);
        check("b_count1", 32'(ifb.fifo_count), 32'(1));
        vb = 7'h61;
        drive_bit(1, 1'b0, CPB_B);
        for (int i = 0; i < 4; i++) drive_bit(1, vb[i], CPB_B);
        rx_b = vb[4];
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_busy_b", 32'(ifb.busy), 32'(1'b0));
        check("mrst_count_b", 32'(ifb.fifo_count), 32'(0));
        rx_b = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        send_b(7'h61, par_odd(7'h61), 1'b1);
        expect_head(1, "b61", 9'h061, 1'b0, 1'b0);
        send_b(7'h61, ~par_odd(7'h61), 1'b1);
        expect_head(1, "b61_par", 9'h061, 1'b1, 1'b0);
        send_b(7'h61, par_odd(7'h61), 1'b0);
        expect_head(1, "b61_stop2", 9'h061, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, successor to the fixed 8-bit even-parity receiver on the control path of the VGA design. Frame format is configurable: data width, parity mode, stop-bit count and bit period. Received words are buffered in a show-ahead FIFO with per-word error flags and a valid/ready read interface. Sits between the board Rx pin and the command/register decoder.

Parameters:
CLKS_PER_BIT, 32, clk cycles per UART bit (>=4; 32 = 320 ns bit at 100 MHz)
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY_MODE, 1, 0 = none, 1 = even (parity bit = XOR of data), 2 = odd
STOP_BITS, 1, stop bits checked (1 or 2)
FIFO_DEPTH, 4, entries, power of 2, >=2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx  in  1  serial input, idle high, asynchronous to clk
rd_ready  in  1  consumer accepts the head word
rd_valid  out  1  FIFO not empty; head word present
rd_data  out  DATA_BITS  head word
rd_parity_err  out  1  parity error flag of head word
rd_frame_err  out  1  stop-bit error flag of head word
overrun  out  1  sticky: a frame was dropped because the FIFO was full
fifo_count  out  clog2(FIFO_DEPTH)+1  entries held
busy  out  1  receiver not in IDLE

Behaviour:
- Reset (rst low, async): FSM to IDLE; FIFO empty; all outputs 0; synchroniser flops preset to 1.
- rx passes through a 2-flop synchroniser. All decisions use the synchronised value rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on rxs == 0, go to START and clear the bit counter. busy = 1 in every state except IDLE.
- START: sample at count CLKS_PER_BIT/2-1. If rxs == 1, treat as a glitch: return to IDLE, push nothing. If rxs == 0, go to DATA. From here every sample is taken CLKS_PER_BIT cycles after the previous one, at mid-bit.
- DATA: shift DATA_BITS samples in LSB first. Then go to PARITY if PARITY_MODE != 0, else go to STOP.
- PARITY: sample the parity bit. parity_err = sample != (^data ^ (PARITY_MODE == 2)).
- STOP: sample STOP_BITS bits. frame_err = 1 if any stop sample is 0. After the last stop sample, push {data, parity_err, frame_err} and go to IDLE in the same cycle. A start bit immediately following the stop bit is therefore caught; there is no dead time.
- Frames with errors are still pushed, with their flags set.
- Frame latency: the word is visible on rd_valid 1 cycle after the final stop sample. The 2-cycle synchroniser delay is additional to this.
- FIFO is show-ahead. rd_data and the two flags are valid whenever rd_valid = 1. A pop happens when rd_valid && rd_ready. rd_ready while empty is ignored.
- Push while full with no pop in the same cycle: the frame is dropped, overrun is set to 1, and FIFO contents are unchanged.
- Push and pop in the same cycle while full: both occur, no overrun, count unchanged.
- Push and pop in the same cycle while empty: not permitted, since rd_valid = 0 while empty. The word appears in the next cycle.
- overrun clears on the first pop after it was set, or on reset.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- rx held low indefinitely (break): a frame with frame_err = 1 and data = 0 is pushed. The FSM then re-enters START only after rxs is seen at 1 in IDLE, i.e. it does not free-run on a stuck-low line.
- Reset asserted mid-frame: the partial frame is discarded. After release, reception restarts on the next falling edge.

Test Plan:
- Defaults, rd_ready = 1. Send 0xD1 with even parity bit 0 and stop 1 -> one pop, rd_data = 0xD1, both flags 0, overrun 0.
- Send 0x35 with parity bit inverted to 1 -> rd_data = 0x35, rd_parity_err = 1, rd_frame_err = 0. Send 0x4A with stop = 0 -> rd_frame_err = 1. Then drive rx high -> the next frame 0x5D is received clean.
- Low pulse of 8 clks on idle rx -> no push, fifo_count stays 0, busy returns to 0 within CLKS_PER_BIT/2+3 clks.
- rd_ready = 0. Send 0x61, 0x7E, 0x87, 0x21 back-to-back -> fifo_count = 4, no overrun. Send 0x66 -> overrun = 1, fifo_count = 4. Raise rd_ready -> pops 0x61, 0x7E, 0x87, 0x21 in order; overrun clears after the first pop.
- FIFO full, with rd_ready pulsed exactly in the push cycle of a fifth frame 0x00 -> 0x61 popped, 0x00 accepted, overrun stays 0, count stays 4.
- Reset low during data bit 4 of 0xE1 -> FIFO empty, busy = 0. Send 0xE1 after release -> received correctly. Repeat with PARITY_MODE = 2, DATA_BITS = 7, STOP_BITS = 2, CLKS_PER_BIT = 16 -> same results, and a 0 in the second stop bit sets rd_frame_err = 1.
